// File: rtl/rip_branch_resolve_queue.sv
// rtl/rip_branch_resolve_queue.sv - in-order branch resolve queue feeding predictor updates
// Optional statistics counters compiled in with RIP_BP_STATS_EN.
module rip_branch_resolve_queue #(
  parameter int INDEX_W  = 10,
  parameter int WEIGHT_W = 2,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [INDEX_W-1:0]       enq_index,
  input  logic [WEIGHT_W-1:0]      enq_weight,
  input  logic                     enq_pred,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     res_ready,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     mispredict,
  output logic                     update,
  output logic [INDEX_W-1:0]       update_index,
  output logic [WEIGHT_W-1:0]      update_weight,
  output logic                     actual,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              stat_resolved,
  output logic [31:0]              stat_mispredict
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [INDEX_W-1:0]  idx_mem  [DEPTH];
  logic [WEIGHT_W-1:0] w_mem    [DEPTH];
  logic                pred_mem [DEPTH];
  logic [PW-1:0]       head, tail;
  logic                res_acc, mis, enq_acc;

  assign enq_ready = (count != FULL);
  assign res_ready = (count != '0);

  assign res_acc = res_valid & res_ready & ~stall & ~flush;
  assign mis     = res_acc & (pred_mem[head] != res_taken);
  // a mispredict makes any same-cycle fetch wrong-path, so it is dropped too
  assign enq_acc = enq_valid & enq_ready & ~flush & ~mis;

  always_ff @(posedge clk) begin
    if (enq_acc) begin
      idx_mem[tail]  <= enq_index;
      w_mem[tail]    <= enq_weight;
      pred_mem[tail] <= enq_pred;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      update        <= 1'b0;
      update_index  <= '0;
      update_weight <= '0;
      actual        <= 1'b0;
      mispredict    <= 1'b0;
    end else begin
      update     <= res_acc;
      mispredict <= mis;
      if (res_acc) begin
        update_index  <= idx_mem[head];
        update_weight <= w_mem[head];
        actual        <= res_taken;
      end
      if (flush || mis) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq_acc) tail <= tail + PW'(1);
        if (res_acc) head <= head + PW'(1);
        count <= count + CW'(enq_acc) - CW'(res_acc);
      end
    end
  end

`ifdef RIP_BP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved   <= '0;
      stat_mispredict <= '0;
    end else begin
      if (res_acc && stat_resolved != 32'hFFFF_FFFF)
        stat_resolved <= stat_resolved + 32'd1;
      if (mis && stat_mispredict != 32'hFFFF_FFFF)
        stat_mispredict <= stat_mispredict + 32'd1;
    end
  end
`else
  assign stat_resolved   = '0;
  assign stat_mispredict = '0;
`endif

endmodule

// File: tb/tb_rip_branch_resolve_queue.sv
// tb/tb_rip_branch_resolve_queue.sv - randomized self-checking bench with queue reference model
module tb_rip_branch_resolve_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, enq_valid, enq_pred, res_valid, res_taken, stall, flush;
  logic [9:0]  enq_index;
  logic [1:0]  enq_weight;
  logic        enq_ready, res_ready, mispredict, update, actual;
  logic [9:0]  update_index;
  logic [1:0]  update_weight;
  logic [3:0]  count;
  logic [31:0] stat_resolved, stat_mispredict;

  rip_branch_resolve_queue dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_index(enq_index), .enq_weight(enq_weight), .enq_pred(enq_pred),
    .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
    .stall(stall), .flush(flush), .mispredict(mispredict), .update(update),
    .update_index(update_index), .update_weight(update_weight), .actual(actual),
    .count(count), .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] idx;
    logic [1:0] w;
    logic       pred;
  } ent_t;

  ent_t        mq[$];
  int          nvec = 0;
  int          nerr = 0;
  logic        e_upd, e_mis, e_act;
  logic [9:0]  e_idx;
  logic [1:0]  e_w;
  logic [31:0] s_res, s_mis, es_res, es_mis;

  task automatic set_stats_exp();
`ifdef RIP_BP_STATS_EN
    es_res = s_res;
    es_mis = s_mis;
`else
    es_res = 32'd0;
    es_mis = 32'd0;
`endif
  endtask

  // Drives one cycle and advances the reference model from the specification's rules
  task automatic drive(input logic ev, input logic [9:0] ei, input logic [1:0] ew, input logic ep,
                       input logic rv, input logic rt, input logic st, input logic fl);
    int   sz;
    logic racc, m;
    ent_t e, n;
    enq_valid = ev; enq_index = ei; enq_weight = ew; enq_pred = ep;
    res_valid = rv; res_taken = rt; stall = st; flush = fl;
    sz = mq.size();
    racc = rv && sz > 0 && !st && !fl;
    m = 1'b0;
    e_upd = 1'b0;
    e_mis = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      if (racc) begin
        e = mq.pop_front();
        e_upd = 1'b1; e_idx = e.idx; e_w = e.w; e_act = rt;
        m = (e.pred != rt);
        e_mis = m;
        if (s_res != 32'hFFFF_FFFF) s_res++;
        if (m && s_mis != 32'hFFFF_FFFF) s_mis++;
        if (m) mq.delete();
      end
      if (!m && ev && sz < DEPTH) begin
        n.idx = ei; n.w = ew; n.pred = ep;
        mq.push_back(n);
      end
    end
    set_stats_exp();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 10'd0, 2'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    s_res = 0; s_mis = 0;
    e_upd = 0; e_mis = 0; e_idx = 0; e_w = 0; e_act = 0;
    set_stats_exp();
  endtask

  task automatic test_reset();
    drive(1, 10'd7, 2'd1, 1, 0, 0, 0, 0);
    do_reset();
    nvec++; if (count !== 4'd0) begin nerr++; $display("FAIL reset_count got %0d want 0", count); end
    nvec++; if (update !== 1'b0 || mispredict !== 1'b0 || actual !== 1'b0) begin
      nerr++; $display("FAIL reset_flags got upd=%0b mis=%0b act=%0b want 0", update, mispredict, actual); end
    nvec++; if (update_index !== 10'd0 || update_weight !== 2'd0) begin
      nerr++; $display("FAIL reset_payload got idx=%0d w=%0d want 0", update_index, update_weight); end
    nvec++; if (enq_ready !== 1'b1 || res_ready !== 1'b0) begin
      nerr++; $display("FAIL reset_ready got enq=%0b res=%0b want 1/0", enq_ready, res_ready); end
    nvec++; if (stat_resolved !== 32'd0 || stat_mispredict !== 32'd0) begin
      nerr++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_resolved, stat_mispredict); end
  endtask

  task automatic test_basic();
    drive(1, 10'd5, 2'd2, 1, 0, 0, 0, 0);
    nvec++; if (count !== 4'd1) begin nerr++; $display("FAIL basic_count1 got %0d want 1", count); end
    drive(0, 10'd0, 2'd0, 0, 1, 1, 0, 0);
    nvec++; if (update !== 1'b1 || update_index !== 10'd5 || update_weight !== 2'd2 || actual !== 1'b1) begin
      nerr++; $display("FAIL basic_update got u=%0b i=%0d w=%0d a=%0b want 1/5/2/1", update, update_index, update_weight, actual); end
    nvec++; if (mispredict !== 1'b0 || count !== 4'd0) begin
      nerr++; $display("FAIL basic_mis_count got m=%0b c=%0d want 0/0", mispredict, count); end
    idle();
    nvec++; if (update !== 1'b0) begin nerr++; $display("FAIL basic_pulse got %0b want 0", update); end
  endtask

  task automatic test_mispredict();
    drive(1, 10'd11, 2'd0, 0, 0, 0, 0, 0);
    drive(1, 10'd12, 2'd1, 1, 0, 0, 0, 0);
    drive(1, 10'd13, 2'd3, 1, 0, 0, 0, 0);
    drive(0, 10'd0, 2'd0, 0, 1, 1, 0, 0);
    nvec++; if (mispredict !== 1'b1 || update !== 1'b1 || update_index !== 10'd11) begin
      nerr++; $display("FAIL mis_pulse got m=%0b u=%0b i=%0d want 1/1/11", mispredict, update, update_index); end
    nvec++; if (count !== 4'd0) begin nerr++; $display("FAIL mis_count got %0d want 0", count); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 10'd0, 2'd0, 0, 1, 1, 0, 0);
      nvec++; if (update !== 1'b0 || mispredict !== 1'b0) begin
        nerr++; $display("FAIL mis_wrongpath got u=%0b m=%0b want 0/0", update, mispredict); end
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) drive(1, 10'(100 + i), 2'(i), 1, 0, 0, 0, 0);
    nvec++; if (enq_ready !== 1'b0 || count !== 4'd8) begin
      nerr++; $display("FAIL full_ready got r=%0b c=%0d want 0/8", enq_ready, count); end
    drive(1, 10'd999, 2'd3, 1, 1, 1, 0, 0);
    nvec++; if (count !== 4'd7 || update_index !== 10'd100) begin
      nerr++; $display("FAIL full_drop got c=%0d i=%0d want 7/100", count, update_index); end
    for (int i = 0; i < 7; i++) begin
      drive(0, 10'd0, 2'd0, 0, 1, 1, 0, 0);
      nvec++; if (update !== 1'b1 || update_index !== e_idx) begin
        nerr++; $display("FAIL full_drain got u=%0b i=%0d want 1/%0d", update, update_index, e_idx); end
    end
    nvec++; if (count !== 4'd0) begin nerr++; $display("FAIL full_empty got %0d want 0", count); end
  endtask

  task automatic test_wrap();
    logic [9:0] v;
    drive(1, 10'd200, 2'd1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      v = 10'($urandom_range(1023));
      drive(i < 10, v, 2'($urandom), 0, 1, 0, 0, 0);
      nvec++; if (update !== 1'b1 || update_index !== e_idx || update_weight !== e_w || mispredict !== 1'b0) begin
        nerr++; $display("FAIL wrap_order got u=%0b i=%0d w=%0d want 1/%0d/%0d", update, update_index, update_weight, e_idx, e_w); end
    end
    nvec++; if (count !== 4'd0) begin nerr++; $display("FAIL wrap_count got %0d want 0", count); end
  endtask

  task automatic test_flush_stall();
    drive(1, 10'd40, 2'd2, 1, 0, 0, 0, 0);
    drive(1, 10'd41, 2'd2, 1, 0, 0, 0, 0);
    drive(1, 10'd42, 2'd0, 1, 1, 1, 0, 1);
    nvec++; if (count !== 4'd0 || update !== 1'b0 || mispredict !== 1'b0) begin
      nerr++; $display("FAIL flush got c=%0d u=%0b m=%0b want 0/0/0", count, update, mispredict); end
    drive(1, 10'd43, 2'd1, 1, 0, 0, 0, 0);
    drive(0, 10'd0, 2'd0, 0, 1, 0, 1, 0);
    nvec++; if (update !== 1'b0 || mispredict !== 1'b0 || count !== 4'd1) begin
      nerr++; $display("FAIL stall got u=%0b m=%0b c=%0d want 0/0/1", update, mispredict, count); end
    drive(0, 10'd0, 2'd0, 0, 1, 1, 0, 0);
    nvec++; if (update !== 1'b1 || update_index !== 10'd43) begin
      nerr++; $display("FAIL stall_release got u=%0b i=%0d want 1/43", update, update_index); end
  endtask

  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 10'(300 + i), 2'd1, 1, 0, 0, 0, 0);
    drive(0, 10'd0, 2'd0, 0, 1, 1, 0, 0);
    drive(0, 10'd0, 2'd0, 0, 1, 1, 0, 0);
    drive(1, 10'd310, 2'd0, 0, 1, 1, 0, 0);
    drive(0, 10'd0, 2'd0, 0, 1, 0, 0, 0);
`ifdef RIP_BP_STATS_EN
    nvec++; if (stat_resolved !== 32'd4 || stat_mispredict !== 32'd1) begin
      nerr++; $display("FAIL stats got %0d/%0d want 4/1", stat_resolved, stat_mispredict); end
`else
    nvec++; if (stat_resolved !== 32'd0 || stat_mispredict !== 32'd0) begin
      nerr++; $display("FAIL stats got %0d/%0d want 0/0", stat_resolved, stat_mispredict); end
`endif
    drive(1, 10'd320, 2'd3, 1, 0, 0, 0, 0);
    drive(1, 10'd321, 2'd3, 1, 0, 0, 0, 0);
    res_valid = 1'b1; res_taken = 1'b0;
    do_reset();
    res_valid = 1'b0;
    nvec++; if (count !== 4'd0 || update !== 1'b0 || mispredict !== 1'b0 || update_index !== 10'd0
                || stat_resolved !== 32'd0 || stat_mispredict !== 32'd0) begin
      nerr++; $display("FAIL midrun_reset got c=%0d u=%0b m=%0b i=%0d s=%0d/%0d want all 0",
                       count, update, mispredict, update_index, stat_resolved, stat_mispredict); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3) != 0, 10'($urandom), 2'($urandom), 1'($urandom),
            $urandom_range(1) == 1, 1'($urandom_range(7) != 0), $urandom_range(3) == 0,
            $urandom_range(39) == 0);
      nvec++;
      if (update !== e_upd || mispredict !== e_mis || count !== 4'(mq.size())
          || (e_upd && (update_index !== e_idx || update_weight !== e_w || actual !== e_act))
          || stat_resolved !== es_res || stat_mispredict !== es_mis
          || enq_ready !== (mq.size() != DEPTH) || res_ready !== (mq.size() != 0)) begin
        nerr++;
        $display("FAIL random[%0d] got u=%0b m=%0b c=%0d i=%0d w=%0d a=%0b s=%0d/%0d want u=%0b m=%0b c=%0d i=%0d w=%0d a=%0b s=%0d/%0d",
                 i, update, mispredict, count, update_index, update_weight, actual, stat_resolved, stat_mispredict,
                 e_upd, e_mis, mq.size(), e_idx, e_w, e_act, es_res, es_mis);
      end
    end
  endtask

  initial begin
    rst = 1'b1; enq_valid = 0; enq_index = 0; enq_weight = 0; enq_pred = 0;
    res_valid = 0; res_taken = 0; stall = 0; flush = 0;
    s_res = 0; s_mis = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_mispredict();
    test_full();
    test_wrap();
    test_flush_stall();
    test_stats();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rip_branch_resolve_queue.md
RIP_BRANCH_RESOLVE_QUEUE -- requirements
Module: rip_branch_resolve_queue

Interface
REQ-001 SHALL have parameter INDEX_W, default 10, predictor table index width.
REQ-002 SHALL have parameter WEIGHT_W, default 2, predictor weight/counter width.
REQ-003 SHALL have parameter DEPTH, default 8, in-flight branch entries; power of two, at least 2.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port enq_valid  input  1  fetch presents a predicted branch.
REQ-007 SHALL have port enq_ready  output  1  queue can accept an entry.
REQ-008 SHALL have port enq_index  input  INDEX_W  predictor index captured at prediction.
REQ-009 SHALL have port enq_weight  input  WEIGHT_W  predictor weight captured at prediction.
REQ-010 SHALL have port enq_pred  input  1  predicted direction (1 = taken).
REQ-011 SHALL have port res_valid  input  1  execute resolves the oldest outstanding branch.
REQ-012 SHALL have port res_taken  input  1  actual direction.
REQ-013 SHALL have port res_ready  output  1  at least one entry outstanding.
REQ-014 SHALL have port stall  input  1  pipeline stall; blocks resolution.
REQ-015 SHALL have port flush  input  1  external flush (trap/redirect); discards all entries.
REQ-016 SHALL have port mispredict  output  1  one-cycle pulse, resolved direction differed from prediction.
REQ-017 SHALL have ports update (1), update_index (INDEX_W), update_weight (WEIGHT_W), actual (1), all outputs, driving the predictor update port.
REQ-018 SHALL have port count  output  $clog2(DEPTH)+1  entries outstanding.
REQ-019 SHALL have ports stat_resolved and stat_mispredict, outputs, 32 bits each, statistics counters.

Function
REQ-020 SHALL store entries in a circular buffer; head/tail pointers wrap modulo DEPTH.
REQ-021 SHALL drive enq_ready = (count != DEPTH) and res_ready = (count != 0), combinationally from registered state.
REQ-022 SHALL accept an entry when enq_valid & enq_ready & ~flush & ~kill, where kill = resolution accepted this cycle with mispredict.
REQ-023 SHALL accept a resolution when res_valid & res_ready & ~stall & ~flush; resolutions are strictly in order (oldest first).
REQ-024 SHALL, one cycle after an accepted resolution, assert update=1 with update_index/update_weight of the dequeued entry and actual=res_taken; otherwise update=0.
REQ-025 SHALL assert mispredict for that same cycle iff stored pred != res_taken.
REQ-026 SHALL, on a mispredicting resolution, empty the whole queue (younger entries are wrong-path) in the same edge; count=0 next cycle.
REQ-027 SHALL, on a correct resolution with simultaneous accepted enqueue, keep count unchanged and move both pointers.
REQ-028 SHALL give flush priority over everything: queue emptied, same-cycle enqueue and resolution discarded, update=0 and mispredict=0 next cycle.
REQ-029 SHALL not accept an enqueue when full even if a resolution occurs in the same cycle.
REQ-030 SHALL hold update/mispredict at 0 while stall=1; outstanding entries are preserved.
REQ-031 SHALL ignore res_valid when empty and enq_valid when full (no state change, no error).
REQ-032 SHALL register update, update_index, update_weight, actual, mispredict (no combinational path from inputs).

Reset
REQ-033 SHALL, on rst=1 at a clock edge, clear pointers, count=0, update=0, update_index=0, update_weight=0, actual=0, mispredict=0, statistics=0.
REQ-034 SHALL, on reset mid-operation, discard all entries and any pending update; first update may occur two cycles after rst deasserts.

Configuration
REQ-035 SHALL use macro RIP_BP_STATS_EN to compile the statistics counters in or out.
REQ-036 SHALL, with RIP_BP_STATS_EN defined, increment stat_resolved per accepted resolution and stat_mispredict per mispredict, both saturating at 32'hFFFF_FFFF.
REQ-037 SHALL, without RIP_BP_STATS_EN, keep both stat ports present and tied to 0, with no counter logic.

Verification
REQ-038 SHALL cover: enqueue idx 5/w 2/pred 1, resolve taken -> next cycle update=1, update_index=5, update_weight=2, actual=1, mispredict=0, count=0.
REQ-039 SHALL cover: enqueue 3 entries, resolve oldest (pred 0) taken -> mispredict=1 one cycle, count=0, other two never produce update.
REQ-040 SHALL cover: fill DEPTH=8 entries -> enq_ready=0; enq_valid plus correct resolution same cycle -> count=7, enqueue dropped.
REQ-041 SHALL cover: 10 enqueue/resolve pairs through DEPTH=8 -> pointer wrap, updates in FIFO order with correct indices.
REQ-042 SHALL cover: flush with res_valid and enq_valid same cycle -> count=0, update=0, mispredict=0 next cycle; stall=1 with res_valid -> no update, count unchanged.
REQ-043 SHALL cover: with RIP_BP_STATS_EN, 4 resolutions of which 1 mispredicts -> stat_resolved=4, stat_mispredict=1; without macro -> both 0; rst mid-run -> all outputs 0.
